dtl_target_interface: RTL
=========================

DTL_TARGET_INTERFACE -- requirements
Module: dtl_target_interface

Interface
REQ-001 SHALL have parameter INTERFACE_WIDTH, default 32, data width in bits (multiple of 8).
REQ-002 SHALL have parameter INTERFACE_ADDR_WIDTH, default 32, DTL byte-address width.
REQ-003 SHALL have parameter INTERFACE_BLOCK_WIDTH, default 5, block-size field width.
REQ-004 SHALL have parameter MEM_ADDR_WIDTH, default 10, memory word-address width.
REQ-005 SHALL have parameter NUM_ENABLES, default INTERFACE_WIDTH/8, byte enables per word.
REQ-006 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-007 iClk  in  1  single clock, all state on rising edge.
REQ-008 iReset_n  in  1  asynchronous active-low reset.
REQ-009 iDTL_CommandValid  in  1 / oDTL_CommandAccept  out  1  command handshake.
REQ-010 iDTL_CommandReadWrite  in  1  1=read, 0=write.
REQ-011 iDTL_Address  in  INTERFACE_ADDR_WIDTH  byte start address.
REQ-012 iDTL_BlockSize  in  INTERFACE_BLOCK_WIDTH  beats minus one.
REQ-013 iDTL_WriteValid  in  1 / oDTL_WriteAccept  out  1  write-data handshake.
REQ-014 iDTL_WriteData  in  INTERFACE_WIDTH; iDTL_WriteEnable  in  NUM_ENABLES; iDTL_WriteLast  in  1.
REQ-015 oDTL_ReadValid  out  1 / iDTL_ReadAccept  in  1  read-data handshake.
REQ-016 oDTL_ReadData  out  INTERFACE_WIDTH; oDTL_ReadLast  out  1.
REQ-017 oMemEnable  out  1; oMemWrite  out  1; oMemAddress  out  MEM_ADDR_WIDTH; oMemByteEnable  out  NUM_ENABLES; oMemWriteData  out  INTERFACE_WIDTH; iMemReadData  in  INTERFACE_WIDTH (valid exactly one cycle after a read enable).

Function
REQ-018 FSM states IDLE, WRITE, READ; handshake = Valid & Accept same rising edge.
REQ-019 oDTL_CommandAccept SHALL be 1 only in IDLE with read buffer empty; command handshake latches word address = iDTL_Address >> log2(NUM_ENABLES) (low MEM_ADDR_WIDTH bits), beat counter = iDTL_BlockSize, goes to WRITE or READ.
REQ-020 WRITE: oDTL_WriteAccept=1; each write handshake drives oMemEnable=1, oMemWrite=1, current address, iDTL_WriteEnable, iDTL_WriteData combinationally in that cycle; address +1, counter -1.
REQ-021 Write handshake with counter==0 ends transfer -> IDLE next cycle; length governed by BlockSize, not WriteLast.
REQ-022 READ: issue memory read (oMemEnable=1, oMemWrite=0) whenever beats remain and buffer free slots exceed reads in flight; returned word enters 2-entry read buffer one cycle later.
REQ-023 oDTL_ReadValid = buffer non-empty; oDTL_ReadData = buffer head; oDTL_ReadLast=1 on beat index BlockSize; READ -> IDLE after last read handshake.
REQ-024 Latency: command handshake at edge T -> first ReadValid after edge T+2; with iDTL_ReadAccept held 1, one beat per cycle, no bubbles.
REQ-025 ReadValid/ReadData/ReadLast SHALL stay stable while ReadAccept=0; no data loss, no duplication.
REQ-026 Word address wraps modulo 2^MEM_ADDR_WIDTH within a block.
REQ-027 oMemEnable=0 whenever no handshake/issue occurs; oMemByteEnable=0 when oMemWrite=0.
REQ-028 CommandValid and WriteValid asserted in the same cycle (master behaviour): command accepted first, write data accepted from next cycle.

Reset
REQ-029 iReset_n=0 SHALL immediately force IDLE, empty buffer, counters 0, all outputs 0 except oDTL_CommandAccept (1 after release).
REQ-030 Reset mid-transfer SHALL abort it; no memory access after reset assertion.

Configuration
REQ-031 Macro DTL_TARGET_ERROR_CHECK_EN defined: add output oError (1 bit), sticky until reset, set on WriteLast mismatch with final beat or address bits above MEM_ADDR_WIDTH+log2(NUM_ENABLES) nonzero; transfers still complete normally.
REQ-032 Macro undefined: no oError port, no checking logic; WriteLast and upper address bits ignored.

Structure
REQ-033 Package dtl_pkg SHALL hold FSM state enum, READWRITE encodings (READ=1, WRITE=0) and default width constants.
REQ-034 Read buffer SHALL be sub-module dtl_read_buffer (2-entry FIFO, data+last bit, full/empty flags).

Verification
REQ-035 Single write 0x0000_0010, data 0xDEADBEEF, enables 0xF -> one mem write at word 4, WriteAccept one cycle after command.
REQ-036 Read BlockSize 3 at 0x20, ReadAccept=1 -> words 8..11 on 4 consecutive cycles from T+2, ReadLast only on 4th.
REQ-037 Same read, ReadAccept toggled 1,0,0,1,... -> data order 8..11 intact, stable during stalls, no extra mem reads beyond 4.
REQ-038 Write BlockSize 1 at word 1023 (MEM_ADDR_WIDTH=10) -> writes at 1023 then 0.
REQ-039 iReset_n low during 3rd beat of 8-beat read -> outputs 0 same edge, IDLE, next command accepted normally.
REQ-040 With DTL_TARGET_ERROR_CHECK_EN, WriteLast on beat 0 of 2-beat write -> oError=1 after that edge, both beats still written.

Source files
------------

// File: rtl/dtl_pkg.sv
// Shared types and default widths for the DTL target slice.
package dtl_pkg;

    localparam int unsigned DTL_DEFAULT_WIDTH          = 32;
    localparam int unsigned DTL_DEFAULT_ADDR_WIDTH     = 32;
    localparam int unsigned DTL_DEFAULT_BLOCK_WIDTH    = 5;
    localparam int unsigned DTL_DEFAULT_MEM_ADDR_WIDTH = 10;

    localparam logic DTL_READ  = 1'b1;
    localparam logic DTL_WRITE = 1'b0;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StRead  = 2'd2
    } dtlState_e;

endpackage

// File: rtl/dtl_target_interface_if.sv
// DTL command/write/read channels; signal names follow the target's view.
interface dtl_target_interface_if
    import dtl_pkg::*;
#(
    parameter int unsigned INTERFACE_WIDTH       = DTL_DEFAULT_WIDTH,
    parameter int unsigned INTERFACE_ADDR_WIDTH  = DTL_DEFAULT_ADDR_WIDTH,
    parameter int unsigned INTERFACE_BLOCK_WIDTH = DTL_DEFAULT_BLOCK_WIDTH,
    parameter int unsigned NUM_ENABLES           = INTERFACE_WIDTH / 8
);

    logic                             iDTL_CommandValid;
    logic                             oDTL_CommandAccept;
    logic                             iDTL_CommandReadWrite;
    logic [INTERFACE_ADDR_WIDTH-1:0]  iDTL_Address;
    logic [INTERFACE_BLOCK_WIDTH-1:0] iDTL_BlockSize;

    logic                             iDTL_WriteValid;
    logic                             oDTL_WriteAccept;
    logic [INTERFACE_WIDTH-1:0]       iDTL_WriteData;
    logic [NUM_ENABLES-1:0]           iDTL_WriteEnable;
    logic                             iDTL_WriteLast;

    logic                             oDTL_ReadValid;
    logic                             iDTL_ReadAccept;
    logic [INTERFACE_WIDTH-1:0]       oDTL_ReadData;
    logic                             oDTL_ReadLast;

    modport slave (
        input  iDTL_CommandValid, iDTL_CommandReadWrite, iDTL_Address, iDTL_BlockSize,
        input  iDTL_WriteValid, iDTL_WriteData, iDTL_WriteEnable, iDTL_WriteLast,
        input  iDTL_ReadAccept,
        output oDTL_CommandAccept, oDTL_WriteAccept,
        output oDTL_ReadValid, oDTL_ReadData, oDTL_ReadLast
    );

    modport master (
        output iDTL_CommandValid, iDTL_CommandReadWrite, iDTL_Address, iDTL_BlockSize,
        output iDTL_WriteValid, iDTL_WriteData, iDTL_WriteEnable, iDTL_WriteLast,
        output iDTL_ReadAccept,
        input  oDTL_CommandAccept, oDTL_WriteAccept,
        input  oDTL_ReadValid, oDTL_ReadData, oDTL_ReadLast
    );

endinterface

// File: rtl/dtl_read_buffer.sv
// Two-entry FIFO holding returned read words with their last-beat flag.
module dtl_read_buffer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             iClk,
    input  logic             iReset_n,
    input  logic             iPush,
    input  logic [WIDTH-1:0] iData,
    input  logic             iLast,
    input  logic             iPop,
    output logic [WIDTH-1:0] oData,
    output logic             oLast,
    output logic             oFull,
    output logic             oEmpty,
    output logic [1:0]       oCount
);

    logic [WIDTH-1:0] dataQ [2];
    logic [1:0]       lastQ;
    logic             wrPtrQ;
    logic             rdPtrQ;
    logic [1:0]       countQ;

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            dataQ[0] <= '0;
            dataQ[1] <= '0;
            lastQ    <= '0;
            wrPtrQ   <= 1'b0;
            rdPtrQ   <= 1'b0;
            countQ   <= 2'd0;
        end else begin
            if (iPush) begin
                dataQ[wrPtrQ] <= iData;
                lastQ[wrPtrQ] <= iLast;
                wrPtrQ        <= ~wrPtrQ;
            end
            if (iPop) begin
                rdPtrQ <= ~rdPtrQ;
            end
            unique case ({iPush, iPop})
                2'b10:   countQ <= countQ + 2'd1;
                2'b01:   countQ <= countQ - 2'd1;
                default: countQ <= countQ;
            endcase
        end
    end

    assign oEmpty = (countQ == 2'd0);
    assign oFull  = (countQ == 2'd2);
    assign oCount = countQ;
    // Stale entries are masked so the read channel idles at zero.
    assign oData  = oEmpty ? '0 : dataQ[rdPtrQ];
    assign oLast  = oEmpty ? 1'b0 : lastQ[rdPtrQ];

endmodule

// File: rtl/dtl_target_interface.sv
// DTL target bridging block transfers to a single-port word memory.
// Optional DTL_TARGET_ERROR_CHECK_EN adds a sticky oError protocol flag.
module dtl_target_interface
    import dtl_pkg::*;
#(
    parameter int unsigned INTERFACE_WIDTH       = DTL_DEFAULT_WIDTH,
    parameter int unsigned INTERFACE_ADDR_WIDTH  = DTL_DEFAULT_ADDR_WIDTH,
    parameter int unsigned INTERFACE_BLOCK_WIDTH = DTL_DEFAULT_BLOCK_WIDTH,
    parameter int unsigned MEM_ADDR_WIDTH        = DTL_DEFAULT_MEM_ADDR_WIDTH,
    parameter int unsigned NUM_ENABLES           = INTERFACE_WIDTH / 8
) (
    input  logic                       iClk,
    input  logic                       iReset_n,
    dtl_target_interface_if.slave      dtl,
    output logic                       oMemEnable,
    output logic                       oMemWrite,
    output logic [MEM_ADDR_WIDTH-1:0]  oMemAddress,
    output logic [NUM_ENABLES-1:0]     oMemByteEnable,
    output logic [INTERFACE_WIDTH-1:0] oMemWriteData,
    input  logic [INTERFACE_WIDTH-1:0] iMemReadData
`ifdef DTL_TARGET_ERROR_CHECK_EN
    ,
    output logic                       oError
`endif
);

    localparam int unsigned BYTE_SHIFT = $clog2(NUM_ENABLES);
    localparam logic [MEM_ADDR_WIDTH-1:0]        ADDR_ONE = 1;
    localparam logic [INTERFACE_BLOCK_WIDTH-1:0] BEAT_ONE = 1;

    dtlState_e                        stateQ, stateD;
    logic [MEM_ADDR_WIDTH-1:0]        addrQ, addrD;
    logic [INTERFACE_BLOCK_WIDTH-1:0] beatsQ, beatsD;
    logic                             issueMoreQ, issueMoreD;
    logic                             pendingQ, pendingD;
    logic                             pendingLastQ, pendingLastD;

    logic                       cmdAccept, cmdHs, writeAccept, writeHs;
    logic                       lastBeat, readIssue, readPop;
    logic [2:0]                 freeSlots;
    logic [MEM_ADDR_WIDTH-1:0]  cmdWordAddr;
    logic                       bufEmpty, bufFull, bufLast;
    logic [1:0]                 bufCount;
    logic [INTERFACE_WIDTH-1:0] bufData;

    assign cmdWordAddr = dtl.iDTL_Address[BYTE_SHIFT +: MEM_ADDR_WIDTH];
    assign cmdAccept   = (stateQ == StIdle) & bufEmpty & iReset_n;
    assign cmdHs       = dtl.iDTL_CommandValid & cmdAccept;
    assign writeAccept = (stateQ == StWrite);
    assign writeHs     = writeAccept & dtl.iDTL_WriteValid;
    assign lastBeat    = (beatsQ == '0);
    assign readPop     = ~bufEmpty & dtl.iDTL_ReadAccept;

    // A slot being popped this cycle is free by the time the issued word returns.
    assign freeSlots = 3'd2 - {1'b0, bufCount} + {2'b0, readPop};
    assign readIssue = (stateQ == StRead) & issueMoreQ & (freeSlots > {2'b0, pendingQ});

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            stateQ       <= StIdle;
            addrQ        <= '0;
            beatsQ       <= '0;
            issueMoreQ   <= 1'b0;
            pendingQ     <= 1'b0;
            pendingLastQ <= 1'b0;
        end else begin
            stateQ       <= stateD;
            addrQ        <= addrD;
            beatsQ       <= beatsD;
            issueMoreQ   <= issueMoreD;
            pendingQ     <= pendingD;
            pendingLastQ <= pendingLastD;
        end
    end

    always_comb begin
        stateD       = stateQ;
        addrD        = addrQ;
        beatsD       = beatsQ;
        issueMoreD   = issueMoreQ;
        pendingD     = readIssue;
        pendingLastD = readIssue & lastBeat;
        unique case (stateQ)
            StIdle: begin
                if (cmdHs) begin
                    addrD      = cmdWordAddr;
                    beatsD     = dtl.iDTL_BlockSize;
                    issueMoreD = 1'b1;
                    unique case (dtl.iDTL_CommandReadWrite)
                        DTL_READ:  stateD = StRead;
                        DTL_WRITE: stateD = StWrite;
                    endcase
                end
            end
            StWrite: begin
                if (writeHs) begin
                    addrD = addrQ + ADDR_ONE;
                    if (lastBeat) begin
                        stateD = StIdle;
                    end else begin
                        beatsD = beatsQ - BEAT_ONE;
                    end
                end
            end
            StRead: begin
                if (readIssue) begin
                    addrD = addrQ + ADDR_ONE;
                    if (lastBeat) begin
                        issueMoreD = 1'b0;
                    end else begin
                        beatsD = beatsQ - BEAT_ONE;
                    end
                end
                if (readPop & bufLast) begin
                    stateD = StIdle;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    assign oMemEnable     = writeHs | readIssue;
    assign oMemWrite      = writeHs;
    assign oMemAddress    = (writeHs | readIssue) ? addrQ : '0;
    assign oMemByteEnable = writeHs ? dtl.iDTL_WriteEnable : '0;
    assign oMemWriteData  = writeHs ? dtl.iDTL_WriteData : '0;

    dtl_read_buffer #(
        .WIDTH(INTERFACE_WIDTH)
    ) uReadBuffer (
        .iClk    (iClk),
        .iReset_n(iReset_n),
        .iPush   (pendingQ),
        .iData   (iMemReadData),
        .iLast   (pendingLastQ),
        .iPop    (readPop),
        .oData   (bufData),
        .oLast   (bufLast),
        .oFull   (bufFull),
        .oEmpty  (bufEmpty),
        .oCount  (bufCount)
    );

    assign dtl.oDTL_CommandAccept = cmdAccept;
    assign dtl.oDTL_WriteAccept   = writeAccept;
    assign dtl.oDTL_ReadValid     = ~bufEmpty;
    assign dtl.oDTL_ReadData      = bufData;
    assign dtl.oDTL_ReadLast      = bufLast;

`ifdef DTL_TARGET_ERROR_CHECK_EN
    localparam int unsigned UPPER_SHIFT = MEM_ADDR_WIDTH + BYTE_SHIFT;

    logic errorQ, errorD, addrUpperBad, unusedSig;

    assign addrUpperBad = (dtl.iDTL_Address >> UPPER_SHIFT) != '0;
    // WriteLast must coincide exactly with the beat that exhausts BlockSize.
    assign errorD = errorQ | (cmdHs & addrUpperBad)
                  | (writeHs & (dtl.iDTL_WriteLast != lastBeat));

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            errorQ <= 1'b0;
        end else begin
            errorQ <= errorD;
        end
    end

    assign oError    = errorQ;
    assign unusedSig = bufFull;
`else
    logic unusedSig;
    assign unusedSig = ^{bufFull, dtl.iDTL_WriteLast, dtl.iDTL_Address};
`endif

endmodule
